graphic_sprite: RTL and testbench



---
 rtl/pacman_pkg.sv | 31 +++
 rtl/sprite_mover.sv | 94 +++++++++
 rtl/graphic_sprite.sv | 62 ++++++
 tb/tb_graphic_sprite.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared definitions for the Pacman playfield renderer: raster size, colours, direction encoding.
package pacman_pkg;

    localparam int unsigned H_ACTIVE = 640;
    localparam int unsigned V_ACTIVE = 480;
    localparam int unsigned CW       = 8;
    localparam int unsigned COORD_W  = 11;

    localparam logic [CW-1:0] COLOR_NULL   = 8'h00;
    localparam logic [CW-1:0] COLOR_BG     = 8'b01001000;
    localparam logic [CW-1:0] COLOR_WALL   = 8'b00000011;
    localparam logic [CW-1:0] COLOR_SPRITE = 8'b11111100;

    typedef enum logic [2:0] {
        DIR_STOP  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } dir_e;

    // Button decode with priority up > down > left > right; btn==0 maps to STOP.
    function automatic dir_e btn_to_dir(input logic [3:0] btn);
        if (btn[0])      return DIR_UP;
        else if (btn[1]) return DIR_DOWN;
        else if (btn[2]) return DIR_LEFT;
        else if (btn[3]) return DIR_RIGHT;
        else             return DIR_STOP;
    endfunction

endpackage

// File: rtl/sprite_mover.sv
// Frame-tick detector, direction register and clamped sprite position.
module sprite_mover
    import pacman_pkg::*;
#(
    parameter int unsigned BORDER = 16,
    parameter int unsigned SPRITE = 16,
    parameter int unsigned STEP   = 2,
    parameter int unsigned PX0    = 312,
    parameter int unsigned PY0    = 232
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] y_i,
    input  logic [3:0]         btn_i,
    output logic [COORD_W-1:0] pos_x_o,
    output logic [COORD_W-1:0] pos_y_o,
    output logic               frame_tick_o
);

    localparam int unsigned X_MIN = BORDER;
    localparam int unsigned Y_MIN = BORDER;
    localparam int unsigned X_MAX = H_ACTIVE - BORDER - SPRITE;
    localparam int unsigned Y_MAX = V_ACTIVE - BORDER - SPRITE;

    logic [COORD_W-1:0] y_prev_q;
    logic               tick_q, tick_d;
    dir_e               dir_q, dir_d;
    logic [COORD_W-1:0] px_q, px_d, py_q, py_d;
    logic [COORD_W:0]   nx, ny;

    // Rising into the first blanking line gives one tick per frame at any clk/pixel ratio.
    always_comb begin
        tick_d = (y_i == COORD_W'(V_ACTIVE)) && (y_prev_q != COORD_W'(V_ACTIVE));
    end

    // Direction latch and per-tick move; a clamp overrides any button on that cycle.
    always_comb begin
        dir_d = dir_q;
        px_d  = px_q;
        py_d  = py_q;
        nx    = {1'b0, px_q};
        ny    = {1'b0, py_q};
        if (btn_i != 4'd0) dir_d = btn_to_dir(btn_i);
        if (tick_q) begin
            case (dir_q)
                DIR_UP:    ny = {1'b0, py_q} - (COORD_W+1)'(STEP);
                DIR_DOWN:  ny = {1'b0, py_q} + (COORD_W+1)'(STEP);
                DIR_LEFT:  nx = {1'b0, px_q} - (COORD_W+1)'(STEP);
                DIR_RIGHT: nx = {1'b0, px_q} + (COORD_W+1)'(STEP);
                default: ;
            endcase
            if (nx < (COORD_W+1)'(X_MIN)) begin
                px_d  = COORD_W'(X_MIN);
                dir_d = DIR_STOP;
            end else if (nx > (COORD_W+1)'(X_MAX)) begin
                px_d  = COORD_W'(X_MAX);
                dir_d = DIR_STOP;
            end else begin
                px_d = nx[COORD_W-1:0];
            end
            if (ny < (COORD_W+1)'(Y_MIN)) begin
                py_d  = COORD_W'(Y_MIN);
                dir_d = DIR_STOP;
            end else if (ny > (COORD_W+1)'(Y_MAX)) begin
                py_d  = COORD_W'(Y_MAX);
                dir_d = DIR_STOP;
            end else begin
                py_d = ny[COORD_W-1:0];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            y_prev_q <= '0;
            tick_q   <= 1'b0;
            dir_q    <= DIR_STOP;
            px_q     <= COORD_W'(PX0);
            py_q     <= COORD_W'(PY0);
        end else begin
            y_prev_q <= y_i;
            tick_q   <= tick_d;
            dir_q    <= dir_d;
            px_q     <= px_d;
            py_q     <= py_d;
        end
    end

    assign pos_x_o      = px_q;
    assign pos_y_o      = py_q;
    assign frame_tick_o = tick_q;

endmodule

// File: rtl/graphic_sprite.sv
// Playfield plus one player sprite; registered colour mux in front of the DAC.
module graphic_sprite
    import pacman_pkg::*;
#(
    parameter int unsigned BORDER = 16,
    parameter int unsigned SPRITE = 16,
    parameter int unsigned STEP   = 2,
    parameter int unsigned PX0    = 312,
    parameter int unsigned PY0    = 232
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic [3:0]         btn,
    output logic [CW-1:0]      rgb,
    output logic [COORD_W-1:0] pos_x,
    output logic [COORD_W-1:0] pos_y,
    output logic               frame_tick
);

    logic [CW-1:0] rgb_q, rgb_d;
    logic          in_active, in_sprite, in_wall;

    sprite_mover #(
        .BORDER(BORDER),
        .SPRITE(SPRITE),
        .STEP  (STEP),
        .PX0   (PX0),
        .PY0   (PY0)
    ) u_mover (
        .clk         (clk),
        .reset       (reset),
        .y_i         (y),
        .btn_i       (btn),
        .pos_x_o     (pos_x),
        .pos_y_o     (pos_y),
        .frame_tick_o(frame_tick)
    );

    // Region classification; sprite bounds computed one bit wider so pos+SPRITE cannot wrap.
    always_comb begin
        in_active = (x < COORD_W'(H_ACTIVE)) && (y < COORD_W'(V_ACTIVE));
        in_sprite = (x >= pos_x) && ({1'b0, x} < ({1'b0, pos_x} + (COORD_W+1)'(SPRITE)))
                 && (y >= pos_y) && ({1'b0, y} < ({1'b0, pos_y} + (COORD_W+1)'(SPRITE)));
        in_wall   = (x < COORD_W'(BORDER)) || (x >= COORD_W'(H_ACTIVE - BORDER))
                 || (y < COORD_W'(BORDER)) || (y >= COORD_W'(V_ACTIVE - BORDER));
        rgb_d = COLOR_BG;
        if (!in_active)     rgb_d = COLOR_NULL;
        else if (in_sprite) rgb_d = COLOR_SPRITE;
        else if (in_wall)   rgb_d = COLOR_WALL;
    end

    // One-cycle colour pipeline.
    always_ff @(posedge clk) begin
        if (reset) rgb_q <= COLOR_NULL;
        else       rgb_q <= rgb_d;
    end

    assign rgb = rgb_q;

endmodule

// File: tb/tb_graphic_sprite.sv
// Self-checking bench for graphic_sprite: colour scoreboard plus frame-level position model.
module tb_graphic_sprite;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y;
    logic [3:0]  btn;
    logic [7:0]  rgb;
    logic [10:0] pos_x, pos_y;
    logic        frame_tick;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    // Position model: dir 0=stop 1=up 2=down 3=left 4=right
    int m_px, m_py, m_dir;

    graphic_sprite dut (
        .clk       (clk),
        .reset     (reset),
        .x         (x),
        .y         (y),
        .btn       (btn),
        .rgb       (rgb),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int prio(input logic [3:0] b);
        if (b[0])      return 1;
        else if (b[1]) return 2;
        else if (b[2]) return 3;
        else if (b[3]) return 4;
        return 0;
    endfunction

    function automatic logic [7:0] ref_rgb(input int xx, input int yy, input int px, input int py);
        if (xx >= 640 || yy >= 480) return 8'h00;
        if (xx >= px && xx < px + 16 && yy >= py && yy < py + 16) return 8'hFC;
        if (xx < 16 || xx >= 624 || yy < 16 || yy >= 464) return 8'h03;
        return 8'h48;
    endfunction

    task automatic model_reset();
        m_px = 312; m_py = 232; m_dir = 0;
    endtask

    task automatic set_btn(input logic [3:0] b);
        btn = b;
        if (b != 4'd0) m_dir = prio(b);
    endtask

    task automatic pulse_btn(input logic [3:0] b);
        set_btn(b);
        step();
        set_btn(4'd0);
    endtask

    // Drive one pixel, queue its expected colour, compare one cycle later.
    task automatic pix(input int xx, input int yy, input logic [7:0] e);
        logic [7:0] want;
        x = 11'(xx);
        y = 11'(yy);
        exp_q.push_back(e);
        step();
        want = exp_q.pop_front();
        check($sformatf("rgb(%0d,%0d)", xx, yy), 32'(rgb), 32'(want));
    endtask

    task automatic model_move();
        int nx, ny;
        nx = m_px; ny = m_py;
        case (m_dir)
            1: ny = m_py - 2;
            2: ny = m_py + 2;
            3: nx = m_px - 2;
            4: nx = m_px + 2;
            default: ;
        endcase
        if (nx < 16)       begin m_px = 16;  m_dir = 0; end
        else if (nx > 608) begin m_px = 608; m_dir = 0; end
        else m_px = nx;
        if (ny < 16)       begin m_py = 16;  m_dir = 0; end
        else if (ny > 448) begin m_py = 448; m_dir = 0; end
        else m_py = ny;
    endtask

    // Short synthetic frame: 479 -> 480 (two cycles) -> 481 -> 0.
    task automatic frame(input bit chk);
        int ticks;
        ticks = 0;
        x = 11'd0;
        y = 11'd479; step(); ticks += int'(frame_tick);
        y = 11'd480; step(); ticks += int'(frame_tick);
        step();              ticks += int'(frame_tick);
        y = 11'd481; step(); ticks += int'(frame_tick);
        y = 11'd0;   step(); ticks += int'(frame_tick);
        model_move();
        if (btn != 4'd0) m_dir = prio(btn);
        if (chk) begin
            check("tick_count", 32'(ticks), 32'd1);
            check("pos_x", 32'(pos_x), 32'(m_px));
            check("pos_y", 32'(pos_y), 32'(m_py));
        end
    endtask

    initial begin
        reset = 1'b1; btn = 4'd0; x = 11'd0; y = 11'd0;
        model_reset();
        step(); step();
        check("rst_rgb", 32'(rgb), 32'h00);
        check("rst_pos_x", 32'(pos_x), 32'd312);
        check("rst_pos_y", 32'(pos_y), 32'd232);
        check("rst_tick", 32'(frame_tick), 32'd0);
        reset = 1'b0;

        pix(100, 100, 8'h48);
        pix(5, 5, 8'h03);
        pix(639, 479, 8'h03);
        pix(700, 10, 8'h00);
        pix(312, 232, 8'hFC);
        pix(327, 247, 8'hFC);
        pix(328, 232, 8'h48);
        pix(311, 240, 8'h48);
        pix(320, 248, 8'h48);

        // Coasting movement after a single right pulse.
        pulse_btn(4'b1000);
        for (int i = 0; i < 3; i++) frame(1'b1);
        check("coast_x", 32'(pos_x), 32'd318);

        for (int i = 0; i < 16; i++) begin
            int rx, ry;
            if (i < 8) begin
                rx = int'($urandom_range(0, 700));
                ry = int'($urandom_range(0, 479));
            end else begin
                rx = m_px - 2 + int'($urandom_range(0, 19));
                ry = m_py - 2 + int'($urandom_range(0, 19));
            end
            pix(rx, ry, ref_rgb(rx, ry, m_px, m_py));
        end

        // Right wall clamp, hold then release, then back off left.
        set_btn(4'b1000);
        for (int i = 0; i < 200; i++) frame(1'b0);
        check("clamp_x", 32'(pos_x), 32'd608);
        check("clamp_y", 32'(pos_y), 32'd232);
        pix(623, 240, 8'hFC);
        pix(624, 240, 8'h03);
        set_btn(4'd0);
        frame(1'b1);
        frame(1'b1);
        pulse_btn(4'b0100);
        frame(1'b1);
        check("left_x", 32'(pos_x), 32'd606);

        // Up beats down when both pressed.
        pulse_btn(4'b0011);
        frame(1'b1);
        check("prio_y", 32'(pos_y), 32'd230);

        // Button change on the tick cycle applies only from the following tick.
        x = 11'd0;
        y = 11'd479; step();
        y = 11'd480; step();
        check("tick_cycle", 32'(frame_tick), 32'd1);
        btn = 4'b0010;
        step();
        check("tick_cycle_y", 32'(pos_y), 32'd228);
        btn = 4'd0;
        y = 11'd0; step();
        m_py = 228; m_dir = 2;
        frame(1'b1);
        check("down_y", 32'(pos_y), 32'd230);

        // Reset mid-frame while moving.
        reset = 1'b1; step(); reset = 1'b0;
        model_reset();
        pulse_btn(4'b1000);
        for (int i = 0; i < 44; i++) frame(1'b0);
        check("pre_rst_x", 32'(pos_x), 32'd400);
        x = 11'd50; y = 11'd100; step();
        reset = 1'b1; step();
        check("mid_rst_x", 32'(pos_x), 32'd312);
        check("mid_rst_y", 32'(pos_y), 32'd232);
        check("mid_rst_tick", 32'(frame_tick), 32'd0);
        check("mid_rst_rgb", 32'(rgb), 32'h00);
        reset = 1'b0;
        model_reset();
        frame(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
